// File: rtl/otter_cu_fsm_if.sv
// Signal bundle between the OTTER control unit and the datapath/memories.
// The datapath side is the master (supplies IR and flags); the control unit is the slave.
interface otter_cu_fsm_if;
  logic [31:0] IR;
  logic        BR_EQ;
  logic        BR_LT;
  logic        BR_LTU;
  logic        INTR;
  logic        MIE;
  logic        MEM_READY;
  logic        PC_WRITE;
  logic        RF_WRITE;
  logic        MEM_RDEN1;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic        CSR_WE;
  logic        INT_TAKEN;
  logic        MRET_EXEC;
  logic [2:0]  IMMED_SEL;
  logic [2:0]  PC_SOURCE;
  logic [1:0]  STATE;
  logic [31:0] RETIRED;

  modport master (
    output IR, BR_EQ, BR_LT, BR_LTU, INTR, MIE, MEM_READY,
    input  PC_WRITE, RF_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
           INT_TAKEN, MRET_EXEC, IMMED_SEL, PC_SOURCE, STATE, RETIRED
  );

  modport slave (
    input  IR, BR_EQ, BR_LT, BR_LTU, INTR, MIE, MEM_READY,
    output PC_WRITE, RF_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
           INT_TAKEN, MRET_EXEC, IMMED_SEL, PC_SOURCE, STATE, RETIRED
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: state sequencing, strobe decode, interrupt
// pending latch and retired-instruction counter.
//
// state | meaning
// FETCH | instruction memory read
// EXEC  | decode/execute; every non-load completes here
// WB    | wait for load data, then write back and complete
// TRAP  | vector to mtvec for a pending, enabled interrupt
module otter_cu_fsm (
  input logic           CLK,
  input logic           RST,
  otter_cu_fsm_if.slave bus
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [2:0] PCS_PC4    = 3'd0;
  localparam logic [2:0] PCS_JALR   = 3'd1;
  localparam logic [2:0] PCS_BRANCH = 3'd2;
  localparam logic [2:0] PCS_JAL    = 3'd3;
  localparam logic [2:0] PCS_MTVEC  = 3'd4;
  localparam logic [2:0] PCS_MEPC   = 3'd5;

  logic [1:0]  state_q, state_d;
  logic        pending_q;
  logic [31:0] retired_q;

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        is_mret;
  logic        br_taken;
  logic        complete;

  logic        pc_write, rf_write, mem_rden1, mem_rden2, mem_we2;
  logic        csr_we, int_taken, mret_exec;
  logic [2:0]  immed_sel, pc_source;

  logic        unused_ir;

  assign opcode    = bus.IR[6:0];
  assign func3     = bus.IR[14:12];
  assign is_mret   = (opcode == OP_SYSTEM) && (func3 == 3'b000) && (bus.IR[31:20] == 12'h302);
  assign unused_ir = ^{bus.IR[19:15], bus.IR[11:7]};

  // Undefined func3 encodings (010, 011) fall to not-taken.
  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = bus.BR_EQ;
      3'b001:  br_taken = ~bus.BR_EQ;
      3'b100:  br_taken = bus.BR_LT;
      3'b101:  br_taken = ~bus.BR_LT;
      3'b110:  br_taken = bus.BR_LTU;
      3'b111:  br_taken = ~bus.BR_LTU;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    rf_write  = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    pc_source = PCS_PC4;
    complete  = 1'b0;

    case (opcode)
      OP_BRANCH:        immed_sel = IMM_B;
      OP_LUI, OP_AUIPC: immed_sel = IMM_U;
      OP_JAL:           immed_sel = IMM_J;
      OP_STORE:         immed_sel = IMM_S;
      default:          immed_sel = IMM_I;
    endcase

    case (state_q)
      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode == OP_LOAD) begin
          mem_rden2 = 1'b1;
          state_d   = ST_WB;
        end else begin
          pc_write = 1'b1;
          complete = 1'b1;
          case (opcode)
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: rf_write = 1'b1;
            OP_JAL: begin
              rf_write  = 1'b1;
              pc_source = PCS_JAL;
            end
            OP_JALR: begin
              rf_write  = 1'b1;
              pc_source = PCS_JALR;
            end
            OP_BRANCH: pc_source = br_taken ? PCS_BRANCH : PCS_PC4;
            OP_STORE:  mem_we2 = 1'b1;
            OP_SYSTEM: begin
              if (func3 == 3'b001) begin
                csr_we   = 1'b1;
                rf_write = 1'b1;
              end else if (is_mret) begin
                mret_exec = 1'b1;
                pc_source = PCS_MEPC;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WB: begin
        if (bus.MEM_READY) begin
          rf_write = 1'b1;
          pc_write = 1'b1;
          complete = 1'b1;
        end
      end
      default: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        pc_source = PCS_MTVEC;
        state_d   = ST_FETCH;
      end
    endcase

    // MRET returns from a handler, so it never chains straight into another trap.
    if (complete) begin
      state_d = (pending_q && bus.MIE && !is_mret) ? ST_TRAP : ST_FETCH;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_FETCH;
      pending_q <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      // A new request arriving on the trap-entry cycle must survive the clear.
      pending_q <= bus.INTR | (pending_q & (state_d != ST_TRAP));
      if (complete) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign bus.PC_WRITE  = pc_write;
  assign bus.RF_WRITE  = rf_write;
  assign bus.MEM_RDEN1 = mem_rden1;
  assign bus.MEM_RDEN2 = mem_rden2;
  assign bus.MEM_WE2   = mem_we2;
  assign bus.CSR_WE    = csr_we;
  assign bus.INT_TAKEN = int_taken;
  assign bus.MRET_EXEC = mret_exec;
  assign bus.IMMED_SEL = immed_sel;
  assign bus.PC_SOURCE = pc_source;
  assign bus.STATE     = state_q;
  assign bus.RETIRED   = retired_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: per-cycle expected outputs are queued
// as stimulus is driven and compared when sampled on the falling edge.
module tb_otter_cu_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  otter_cu_fsm_if bus ();
  otter_cu_fsm dut (.CLK(clk), .RST(rst), .bus(bus));

  // stb bits: {PC_WRITE, RF_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC}
  typedef struct packed {
    logic [1:0] st;
    logic [7:0] stb;
    logic [2:0] imm;
    logic [2:0] pcs;
  } obs_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [5:0]  fl;
    obs_t        want;
  } step_t;

  localparam logic [7:0] S_PCW  = 8'h80;
  localparam logic [7:0] S_RFW  = 8'h40;
  localparam logic [7:0] S_RD1  = 8'h20;
  localparam logic [7:0] S_RD2  = 8'h10;
  localparam logic [7:0] S_WE2  = 8'h08;
  localparam logic [7:0] S_CSR  = 8'h04;
  localparam logic [7:0] S_INT  = 8'h02;
  localparam logic [7:0] S_MRET = 8'h01;

  // fl bits: {BR_EQ, BR_LT, BR_LTU, INTR, MIE, MEM_READY}
  localparam logic [5:0] F_EQ   = 6'b100000;
  localparam logic [5:0] F_LT   = 6'b010000;
  localparam logic [5:0] F_LTU  = 6'b001000;
  localparam logic [5:0] F_INTR = 6'b000100;
  localparam logic [5:0] F_MIE  = 6'b000010;
  localparam logic [5:0] F_RDY  = 6'b000001;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0000a103;
  localparam logic [31:0] I_SW    = 32'h0020a023;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_JAL   = 32'h008000ef;
  localparam logic [31:0] I_JALR  = 32'h000080e7;
  localparam logic [31:0] I_LUI   = 32'h123450b7;
  localparam logic [31:0] I_AUIPC = 32'h12345097;
  localparam logic [31:0] I_ADD   = 32'h002081b3;
  localparam logic [31:0] I_CSRRW = 32'h30529073;
  localparam logic [31:0] I_MRET  = 32'h30200073;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_BAD   = 32'h0000007f;

  obs_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_ret  = 32'd0;

  function automatic obs_t mk(input logic [1:0] st, input logic [7:0] stb,
                              input logic [2:0] imm, input logic [2:0] pcs);
    return obs_t'({st, stb, imm, pcs});
  endfunction

  function automatic step_t sp(input logic [31:0] ir, input logic [5:0] fl, input obs_t want);
    return step_t'({ir, fl, want});
  endfunction

  function automatic obs_t observe();
    return obs_t'({bus.STATE, bus.PC_WRITE, bus.RF_WRITE, bus.MEM_RDEN1, bus.MEM_RDEN2,
                   bus.MEM_WE2, bus.CSR_WE, bus.INT_TAKEN, bus.MRET_EXEC,
                   bus.IMMED_SEL, bus.PC_SOURCE});
  endfunction

  task automatic drive(input step_t s);
    bus.IR        = s.ir;
    bus.BR_EQ     = s.fl[5];
    bus.BR_LT     = s.fl[4];
    bus.BR_LTU    = s.fl[3];
    bus.INTR      = s.fl[2];
    bus.MIE       = s.fl[1];
    bus.MEM_READY = s.fl[0];
    sb.push_back(s.want);
  endtask

  task automatic test_reset();
    obs_t got, want;
    drive(sp(32'd0, 6'd0, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.STATE !== 2'd0) begin
      failures++;
      $display("FAIL reset_state_async got %0d want 0", bus.STATE);
    end
    checks++;
    if (bus.RETIRED !== 32'd0) begin
      failures++;
      $display("FAIL reset_retired got %h want 0", bus.RETIRED);
    end
    got  = observe();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL reset_outputs got %h want %h", got, want);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_addi();
    step_t steps[$];
    obs_t  got, want;
    steps.push_back(sp(I_ADDI, 6'd0, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, 6'd0, mk(2'd1, S_PCW | S_RFW, 3'd0, 3'd0)));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL addi step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = 32'd1;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL addi_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_decode();
    step_t       steps[$];
    obs_t        got, want;
    logic [31:0] irs [10] = '{I_ADD, I_LUI, I_AUIPC, I_JAL, I_JALR, I_SW, I_CSRRW, I_MRET, I_ECALL, I_BAD};
    logic [7:0]  stbs[10] = '{S_PCW|S_RFW, S_PCW|S_RFW, S_PCW|S_RFW, S_PCW|S_RFW, S_PCW|S_RFW,
                              S_PCW|S_WE2, S_PCW|S_RFW|S_CSR, S_PCW|S_MRET, S_PCW, S_PCW};
    logic [2:0]  imms[10] = '{3'd0, 3'd3, 3'd3, 3'd4, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [2:0]  pcss[10] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
    for (int k = 0; k < 10; k++) begin
      steps.push_back(sp(irs[k], 6'd0, mk(2'd0, S_RD1, imms[k], 3'd0)));
      steps.push_back(sp(irs[k], 6'd0, mk(2'd1, stbs[k], imms[k], pcss[k])));
    end
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL decode instr %0d got %h want %h", i / 2, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd10;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL decode_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_load();
    step_t steps[$];
    obs_t  got, want;
    steps.push_back(sp(I_LW, 6'd0, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_LW, 6'd0, mk(2'd1, S_RD2, 3'd0, 3'd0)));
    repeat (3) steps.push_back(sp(I_LW, 6'd0, mk(2'd2, 8'd0, 3'd0, 3'd0)));
    steps.push_back(sp(I_LW, F_RDY, mk(2'd2, S_PCW | S_RFW, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, F_RDY, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, F_RDY, mk(2'd1, S_PCW | S_RFW, 3'd0, 3'd0)));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd2;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL load_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_branch();
    step_t       steps[$];
    obs_t        got, want;
    logic [31:0] ir;
    logic [2:0]  f3s [15] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b100, 3'b100, 3'b101, 3'b101,
                              3'b110, 3'b110, 3'b111, 3'b111, 3'b010, 3'b011, 3'b010};
    logic [5:0]  fls [15] = '{6'd0, F_EQ, F_EQ, 6'd0, F_LT, 6'd0, 6'd0, F_LT,
                              F_LTU, F_LT, 6'd0, F_LTU, F_EQ|F_LT|F_LTU, F_EQ|F_LT|F_LTU, 6'd0};
    logic        tkn [15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                              1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 15; k++) begin
      ir = I_BNE;
      ir[14:12] = f3s[k];
      steps.push_back(sp(ir, fls[k], mk(2'd0, S_RD1, 3'd2, 3'd0)));
      steps.push_back(sp(ir, fls[k], mk(2'd1, S_PCW, 3'd2, tkn[k] ? 3'd2 : 3'd0)));
    end
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL branch row %0d got %h want %h", i / 2, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd15;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL branch_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_interrupt();
    step_t steps[$];
    obs_t  got, want;
    obs_t  f0, ex, tr;
    f0 = mk(2'd0, S_RD1, 3'd0, 3'd0);
    ex = mk(2'd1, S_PCW | S_RFW, 3'd0, 3'd0);
    tr = mk(2'd3, S_PCW | S_INT, 3'd0, 3'd4);
    // enabled pulse during FETCH -> TRAP after EXEC
    steps.push_back(sp(I_ADDI, F_MIE | F_INTR, f0));
    steps.push_back(sp(I_ADDI, F_MIE, ex));
    steps.push_back(sp(I_ADDI, F_MIE, tr));
    steps.push_back(sp(I_ADDI, F_MIE, f0));
    steps.push_back(sp(I_ADDI, F_MIE, ex));
    // disabled pulse -> no trap, request stays pending
    steps.push_back(sp(I_ADDI, F_INTR, f0));
    steps.push_back(sp(I_ADDI, 6'd0, ex));
    // MRET never traps even with pending and MIE
    steps.push_back(sp(I_MRET, F_MIE, f0));
    steps.push_back(sp(I_MRET, F_MIE, mk(2'd1, S_PCW | S_MRET, 3'd0, 3'd5)));
    // INTR on the trap-entry cycle keeps the request pending
    steps.push_back(sp(I_ADDI, F_MIE, f0));
    steps.push_back(sp(I_ADDI, F_MIE | F_INTR, ex));
    steps.push_back(sp(I_ADDI, F_MIE, tr));
    steps.push_back(sp(I_ADDI, F_MIE, f0));
    steps.push_back(sp(I_ADDI, F_MIE, ex));
    steps.push_back(sp(I_ADDI, F_MIE, tr));
    steps.push_back(sp(I_ADDI, F_MIE, f0));
    steps.push_back(sp(I_ADDI, F_MIE, ex));
    steps.push_back(sp(I_ADDI, F_MIE, f0));
    steps.push_back(sp(I_ADDI, F_MIE, ex));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL intr step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd8;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL intr_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_wrap();
    step_t steps[$];
    obs_t  got, want;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    steps.push_back(sp(I_ADDI, 6'd0, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, 6'd0, mk(2'd1, S_PCW | S_RFW, 3'd0, 3'd0)));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL wrap step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = 32'd0;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL wrap_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  task automatic test_reset_mid();
    step_t steps[$];
    obs_t  got, want;
    steps.push_back(sp(I_LW, 6'd0, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_LW, 6'd0, mk(2'd1, S_RD2, 3'd0, 3'd0)));
    steps.push_back(sp(I_LW, 6'd0, mk(2'd2, 8'd0, 3'd0, 3'd0)));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rstmid pre step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    // now in WB; reset lands mid-cycle with data about to arrive
    drive(sp(I_LW, F_RDY, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    #2 rst = 1'b1;
    #1;
    got  = observe();
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL rstmid_async got %h want %h", got, want);
    end
    checks++;
    if (bus.RETIRED !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_retired got %h want 0", bus.RETIRED);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    steps.delete();
    steps.push_back(sp(I_ADDI, F_RDY, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, F_RDY, mk(2'd1, S_PCW | S_RFW, 3'd0, 3'd0)));
    steps.push_back(sp(I_ADDI, F_RDY, mk(2'd0, S_RD1, 3'd0, 3'd0)));
    foreach (steps[i]) begin
      drive(steps[i]);
      @(negedge clk);
      got  = observe();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rstmid post step %0d got %h want %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    exp_ret = 32'd1;
    checks++;
    if (bus.RETIRED !== exp_ret) begin
      failures++;
      $display("FAIL rstmid_post_retired got %h want %h", bus.RETIRED, exp_ret);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_load();
    test_branch();
    test_interrupt();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing the sequence");
    $fatal(1);
  end

endmodule

// File: doc/otter_cu_fsm.md
OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: IR  in  32  current instruction from the instruction memory.
REQ-004 SHALL have ports: BR_EQ, BR_LT, BR_LTU  in  1 each  branch comparator flags for rs1 vs rs2.
REQ-005 SHALL have ports: INTR  in  1  external interrupt request, level.
REQ-006 SHALL have ports: MIE  in  1  interrupt enable from CSR file.
REQ-007 SHALL have ports: MEM_READY  in  1  data memory read data valid.
REQ-008 SHALL have ports: PC_WRITE, RF_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE, INT_TAKEN, MRET_EXEC  out  1 each  datapath strobes.
REQ-009 SHALL have ports: IMMED_SEL  out  3  immediate select: 0=I, 1=S, 2=B, 3=U, 4=J.
REQ-010 SHALL have ports: PC_SOURCE  out  3  PC mux select: 0=PC+4, 1=JALR, 2=branch, 3=JAL, 4=mtvec, 5=mepc.
REQ-011 SHALL have ports: STATE  out  2  current state: 0=FETCH, 1=EXEC, 2=WB, 3=TRAP.
REQ-012 SHALL have ports: RETIRED  out  32  count of completed instructions.

Function
REQ-013 SHALL implement four registered states: FETCH, EXEC, WB and TRAP; all strobes SHALL be decoded combinationally from the state, IR and flags, and SHALL be 0 unless stated.
REQ-014 FETCH SHALL assert MEM_RDEN1 and advance to EXEC unconditionally.
REQ-015 EXEC with a load (opcode 0000011) SHALL assert MEM_RDEN2, select IMMED_SEL=0, keep PC_WRITE=0 and advance to WB.
REQ-016 EXEC with any non-load opcode SHALL assert PC_WRITE.
REQ-017 In EXEC, RF_WRITE SHALL be asserted for opcodes 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 and for CSRRW.
REQ-018 In EXEC with a store (0100011), MEM_WE2 SHALL be asserted with IMMED_SEL=1.
REQ-019 IMMED_SEL SHALL be derived from the opcode in every state: B for 1100011, U for LUI/AUIPC, J for JAL, S for store, and I otherwise.
REQ-020 Branch PC_SOURCE SHALL be 2 when taken, else 0, with the taken condition decoded from func3: 000 BR_EQ, 001 !BR_EQ, 100 BR_LT, 101 !BR_LT, 110 BR_LTU, 111 !BR_LTU.
REQ-021 Branches with any other func3 SHALL be treated as not taken.
REQ-022 SYSTEM opcode (1110011) with func3=001 SHALL assert CSR_WE and RF_WRITE.
REQ-023 SYSTEM opcode with func3=000 and IR[31:20]=0x302 SHALL assert MRET_EXEC with PC_SOURCE=5.
REQ-024 Any unrecognised opcode SHALL act as a NOP: PC_WRITE=1, PC_SOURCE=0, no other strobe.
REQ-025 WB SHALL hold, with all strobes 0, while MEM_READY=0; on MEM_READY=1 it SHALL assert RF_WRITE and PC_WRITE (PC_SOURCE=0) in that cycle.
REQ-026 A registered pending flag SHALL set on any cycle with INTR=1 and clear on entry to TRAP; INTR and clear in the same cycle SHALL leave the flag set.
REQ-027 At instruction completion (EXEC non-load, or WB with MEM_READY), next state SHALL be TRAP if pending&&MIE, else FETCH.
REQ-028 An MRET instruction SHALL always go to FETCH.
REQ-029 TRAP SHALL assert INT_TAKEN and PC_WRITE with PC_SOURCE=4, and SHALL advance to FETCH.
REQ-030 RETIRED SHALL increment by 1 on each completion cycle (REQ-027), SHALL not increment in TRAP, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-031 RST=1 SHALL immediately force STATE=FETCH, pending=0 and RETIRED=0, independent of CLK.
REQ-032 Reset asserted mid-WB or mid-TRAP SHALL abandon the instruction with no RF_WRITE or PC_WRITE after reset release.
REQ-033 The first cycle after reset release SHALL be FETCH with MEM_RDEN1=1.

Verification
REQ-034 ADDI (IR=0x00500093) from reset -> FETCH then EXEC with RF_WRITE=1, PC_WRITE=1, IMMED_SEL=0; RETIRED=1.
REQ-035 LW with MEM_READY low 3 cycles -> WB held 3 cycles with strobes 0, then RF_WRITE=PC_WRITE=1 in a single cycle.
REQ-036 BNE with BR_EQ=0 -> PC_SOURCE=2, IMMED_SEL=2; repeated with BR_EQ=1 -> PC_SOURCE=0.
REQ-037 INTR pulsed 1 cycle during FETCH with MIE=1 -> TRAP after EXEC with INT_TAKEN=1, PC_SOURCE=4; with MIE=0 -> no TRAP.
REQ-038 RETIRED preloaded to 0xFFFFFFFF via 2^32 NOPs (or force) -> next completion gives 0.
REQ-039 RST pulsed during WB -> STATE=0 asynchronously, RETIRED=0, no RF_WRITE afterwards.
